// File: rtl/axi_bram2axi_if.sv
// AXI4 write-channel bundle (AW, W, B) used by axi_bram2axi.
// master : drives awvalid/awaddr/awlen, wvalid/wdata/wstrb/wlast, bready
//          and observes awready, wready, bvalid.
// slave  : the memory side, with the opposite directions.
interface axi_bram2axi_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 512
);
  logic                          awvalid;
  logic                          awready;
  logic [AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                    awlen;
  logic                          wvalid;
  logic                          wready;
  logic [AXI_DATA_WIDTH-1:0]     wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                          wlast;
  logic                          bvalid;
  logic                          bready;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/axi_bram2axi.sv
// Drains a local BRAM/URAM result buffer into system memory with AXI4
// write bursts. Buffer words are read at a fixed latency into a skid FIFO
// and sent as full-width beats; bursts split at MAX_BURST_LEN and at 4 KB.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_b2a_start/o_b2a_done  start pulse (accepted when done) / idle flag
//   i_b2a_data_addr         destination byte address (64-byte aligned)
//   i_b2a_data_size_bytes   transfer length in bytes
//   o_b2a_rden/o_b2a_rdaddr buffer read strobe and word address from 0
//   i_b2a_rddata            buffer data, BRAM_DELAY cycles after rden
//   m_axi                   AXI4 AW/W/B master channels
module axi_bram2axi #(
  parameter int AXI_ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH      = 512,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_DELAY          = 3,
  parameter int MAX_BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_b2a_start,
  output logic                           o_b2a_done,
  input  logic [AXI_ADDR_WIDTH-1:0]      i_b2a_data_addr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_b2a_data_size_bytes,
  output logic                           o_b2a_rden,
  output logic [31:0]                    o_b2a_rdaddr,
  input  logic [AXI_DATA_WIDTH-1:0]      i_b2a_rddata,
  axi_bram2axi_if.master                 m_axi
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int LOG_B = $clog2(BYTES);
  localparam int CNT_W = AXI_XFER_SIZE_WIDTH - LOG_B;
  localparam int CW    = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_B} state_t;

  // Beats in the next burst: clamp to remaining, max length and 4 KB page.
  function automatic logic [CNT_W-1:0] burst_len(input logic [CNT_W-1:0] rem,
                                                 input logic [11:0] a_lo);
    logic [CNT_W-1:0] b4k;
    logic [CNT_W-1:0] len;
    b4k = CNT_W'((13'h1000 - {1'b0, a_lo}) >> LOG_B);
    len = (rem < CNT_W'(MAX_BURST_LEN)) ? rem : CNT_W'(MAX_BURST_LEN);
    if (b4k < len) len = b4k;
    return len;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  state_t                    r_state;
  logic                      r_done;
  logic [CNT_W-1:0]          r_total;
  logic [LOG_B-1:0]          r_tail;
  logic [AXI_ADDR_WIDTH-1:0] r_aw_addr, r_w_addr;
  logic [CNT_W-1:0]          r_aw_rem, r_w_rem, r_w_idx, r_rd_cnt;
  logic [OW-1:0]             r_outst, r_aw_ahead;
  logic [BRAM_DELAY-1:0]     r_vld_p;
  logic [CW-1:0]             r_inflight, r_fifo_cnt;
  logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [CNT_W-1:0] w_aw_len, w_w_len, w_start_beats;
  logic             w_awvalid, w_aw_hs, w_b_hs, w_wvalid, w_w_hs;
  logic             w_wlast, w_final, w_burst_end, w_rden, w_push, w_pop;
  logic [BYTES-1:0] w_tail_strb;

  assign w_start_beats = CNT_W'(i_b2a_data_size_bytes >> LOG_B)
                       + CNT_W'(|i_b2a_data_size_bytes[LOG_B-1:0]);

  // AW side walks its own address/remaining pair.
  assign w_aw_len  = burst_len(r_aw_rem, r_aw_addr[11:0]);
  assign w_awvalid = (r_state == S_RUN) && (r_aw_rem != '0) &&
                     (r_outst < OW'(MAX_OUTSTANDING));
  assign w_aw_hs   = w_awvalid && m_axi.awready;
  assign w_b_hs    = m_axi.bvalid && (r_outst != '0);

  // W side re-derives the same burst split; r_aw_ahead counts bursts whose
  // AW is done but whose W has not finished, so W can never lead its AW.
  assign w_w_len     = burst_len(r_w_rem, r_w_addr[11:0]);
  assign w_wlast     = (r_w_idx == w_w_len - CNT_W'(1));
  assign w_final     = w_wlast && (r_w_rem == w_w_len);
  assign w_wvalid    = (r_fifo_cnt != '0) && (r_aw_ahead != '0);
  assign w_w_hs      = w_wvalid && m_axi.wready;
  assign w_burst_end = w_w_hs && w_wlast;
  assign w_tail_strb = (BYTES'(1) << r_tail) - BYTES'(1);

  // Reads are throttled so FIFO entries plus reads in flight never exceed depth.
  assign w_rden = (r_state == S_RUN) && (r_rd_cnt < r_total) &&
                  ((r_fifo_cnt + r_inflight) < CW'(FIFO_DEPTH));
  assign w_push = r_vld_p[BRAM_DELAY-1];
  assign w_pop  = w_w_hs;

  assign o_b2a_done    = r_done;
  assign o_b2a_rden    = w_rden;
  assign o_b2a_rdaddr  = 32'(r_rd_cnt);
  assign m_axi.awvalid = w_awvalid;
  assign m_axi.awaddr  = r_aw_addr;
  assign m_axi.awlen   = 8'(w_aw_len - CNT_W'(1));
  assign m_axi.wvalid  = w_wvalid;
  assign m_axi.wdata   = r_mem[r_rd_ptr];
  assign m_axi.wstrb   = (w_final && (r_tail != '0)) ? w_tail_strb : '1;
  assign m_axi.wlast   = w_wlast;
  assign m_axi.bready  = 1'b1;

  // Stage p0: control FSM, burst counters, read pipeline and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b1;
      r_total    <= '0;
      r_tail     <= '0;
      r_aw_addr  <= '0;
      r_w_addr   <= '0;
      r_aw_rem   <= '0;
      r_w_rem    <= '0;
      r_w_idx    <= '0;
      r_rd_cnt   <= '0;
      r_outst    <= '0;
      r_aw_ahead <= '0;
      r_vld_p    <= '0;
      r_inflight <= '0;
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // done was dropped for a zero-length start; raise it again.
          if (!r_done) begin
            r_done <= 1'b1;
          end else if (i_b2a_start) begin
            r_done    <= 1'b0;
            r_total   <= w_start_beats;
            r_tail    <= i_b2a_data_size_bytes[LOG_B-1:0];
            r_aw_addr <= i_b2a_data_addr;
            r_w_addr  <= i_b2a_data_addr;
            r_aw_rem  <= w_start_beats;
            r_w_rem   <= w_start_beats;
            r_w_idx   <= '0;
            r_rd_cnt  <= '0;
            if (w_start_beats != '0) r_state <= S_RUN;
          end
        end
        S_RUN: if (w_w_hs && w_final) r_state <= S_WAIT_B;
        S_WAIT_B: begin
          if (r_outst == '0 && r_aw_rem == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_aw_hs) begin
        r_aw_addr <= r_aw_addr + (AXI_ADDR_WIDTH'(w_aw_len) << LOG_B);
        r_aw_rem  <= r_aw_rem - w_aw_len;
      end
      if (w_aw_hs != w_b_hs)
        r_outst <= w_aw_hs ? r_outst + OW'(1) : r_outst - OW'(1);
      if (w_aw_hs != w_burst_end)
        r_aw_ahead <= w_aw_hs ? r_aw_ahead + OW'(1) : r_aw_ahead - OW'(1);

      if (w_w_hs) begin
        if (w_wlast) begin
          r_w_idx  <= '0;
          r_w_addr <= r_w_addr + (AXI_ADDR_WIDTH'(w_w_len) << LOG_B);
          r_w_rem  <= r_w_rem - w_w_len;
        end else begin
          r_w_idx  <= r_w_idx + CNT_W'(1);
        end
      end

      if (w_rden) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      r_vld_p[0] <= w_rden;
      for (int k = 1; k < BRAM_DELAY; k++) r_vld_p[k] <= r_vld_p[k-1];
      if (w_rden != w_push)
        r_inflight <= w_rden ? r_inflight + CW'(1) : r_inflight - CW'(1);

      if (w_push != w_pop)
        r_fifo_cnt <= w_push ? r_fifo_cnt + CW'(1) : r_fifo_cnt - CW'(1);
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Stage p1: FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_b2a_rddata;
  end
endmodule

// File: doc/axi_bram2axi.md
Name: axi_bram2axi

Overview:
Write-direction counterpart of the AXI read path. It drains a local BRAM or URAM result buffer into system memory using AXI4 write bursts over the AW, W and B channels. It reads buffer words at a fixed RAM latency, stages them in an internal skid FIFO, and emits full-width beats. Bursts are split at the length limit and at 4 KB boundaries. Completion is signalled only after every write response has been accepted.

Parameters:
- AXI_ADDR_WIDTH, 64, AXI address width.
- AXI_DATA_WIDTH, 512, AXI data width and BRAM word width. BYTES = AXI_DATA_WIDTH/8 = 64.
- AXI_XFER_SIZE_WIDTH, 32, width of the byte-count input.
- BRAM_DELAY, 3, cycles from o_b2a_rden to valid i_b2a_rddata.
- MAX_BURST_LEN, 64, maximum beats per burst; power of two, ≤256.
- MAX_OUTSTANDING, 4, maximum AW bursts issued without a B response.
- FIFO_DEPTH, 8, skid FIFO entries; must be ≥ BRAM_DELAY+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_b2a_start  in  1  one-cycle start pulse; ignored while busy
- o_b2a_done  out  1  high when idle/complete
- i_b2a_data_addr  in  AXI_ADDR_WIDTH  destination byte address, 64-byte aligned
- i_b2a_data_size_bytes  in  AXI_XFER_SIZE_WIDTH  transfer length in bytes
- o_b2a_rden  out  1  buffer read enable
- o_b2a_rdaddr  out  32  buffer word address, starting at 0
- i_b2a_rddata  in  AXI_DATA_WIDTH  buffer read data, BRAM_DELAY cycles after rden
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_awaddr  out  AXI_ADDR_WIDTH
- m_axi_awlen  out  8
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_wdata  out  AXI_DATA_WIDTH
- m_axi_wstrb  out  AXI_DATA_WIDTH/8
- m_axi_wlast  out  1
- m_axi_bvalid  in  1
- m_axi_bready  out  1  tied high

Behaviour:
- Reset values: o_b2a_done=1; rden, awvalid and wvalid are 0; all counters 0; FIFO empty. Reset mid-transfer aborts immediately with no further handshakes.
- Start handling:
  - Start is accepted only when done=1. It latches addr and size, sets total_beats = ceil(size/BYTES), and clears done on the next cycle.
  - Start while busy is ignored.
  - size=0: done is low for exactly one cycle and then returns to 1; no AXI traffic occurs.
- FSM:
  - IDLE -> RUN on an accepted start with size≠0.
  - RUN -> WAIT_B when the last W beat handshakes.
  - WAIT_B -> IDLE when outstanding==0 and all bursts have received B. done rises in the same cycle that IDLE is entered.
- Burst length: len = min(remaining_beats, MAX_BURST_LEN, beats_to_4KB_boundary), where beats_to_4KB = (4096 - addr[11:0])/BYTES. The AW and W sides evaluate the same rule independently.
- AW channel:
  - awvalid is asserted while bursts remain and outstanding < MAX_OUTSTANDING.
  - awaddr and awlen (= len-1) stay stable until awready.
  - On handshake: addr += len*BYTES and outstanding++.
- B channel: outstanding decrements on each bvalid. If AW and B handshake in the same cycle, outstanding is unchanged.
- Buffer reads:
  - rden is asserted while beats_read < total_beats and (fifo_count + in_flight) < FIFO_DEPTH.
  - rdaddr increments per rden. A BRAM_DELAY-deep valid shift register pushes i_b2a_rddata into the FIFO.
  - The FIFO never overflows or drops data.
- W channel:
  - wvalid = FIFO non-empty AND the AW for the current W burst has already handshaked. W never leads its AW.
  - wdata = FIFO head. wlast is asserted on the final beat of each burst.
  - wstrb is all ones, except on the transfer's final beat when size%BYTES≠0; there it is ((1<<(size%BYTES))-1).
  - Data and flags hold stable under wready=0.
- Arithmetic: beat counters are AXI_XFER_SIZE_WIDTH-6 bits wide; the address adder is full AXI_ADDR_WIDTH with no wrap handling (software guarantees range). Simultaneous FIFO push and pop leaves the count unchanged.

Test Plan:
1. addr=0x1000_0000, size=0x1000, all ready -> one AW with awlen=63; 64 W beats with wdata = buffer words 0..63 and wlast on beat 63; done rises after B.
2. addr=0x2000_0000, size=0x2040 -> awaddr 0x2000_0000 / 0x2000_1000 / 0x2000_2000 with awlen 63 / 63 / 0; 129 beats total.
3. addr=0x0FC0, size=0x50 -> 4 KB split: burst 1 is 1 beat at 0x0FC0 with full wstrb; burst 2 is 1 beat at 0x1000 with wstrb=0xFFFF.
4. Random wready at 50% and awready at 30%, size=0x8000 -> byte-exact data in order, no duplicates, FIFO count never exceeds FIFO_DEPTH, W never precedes its AW.
5. bvalid withheld, size=0x8000 -> exactly 4 AWs issued, then awvalid=0 until the first B; done stays 0 until the 8th B.
6. Reset asserted mid-burst, then start with size=0 -> all outputs at reset values and done=1; after start, done is low one cycle then 1, and no AW is issued.
